// File: rtl/axis_pkg.sv
// axis_pkg: shared depth and counter/pointer types for the AXI-Stream buffers.
package axis_pkg;
  localparam int AXIS_BUF_DEPTH = 2;
  typedef logic [1:0] axis_cnt_t;
  typedef logic [0:0] axis_ptr_t;
endpackage

// File: rtl/axis_buffer_2.sv
// axis_buffer_2: 2-entry registered FIFO for one separator branch, no bypass.
module axis_buffer_2
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  push,
  input  logic [DATA_WIDTH-1:0] push_data,
  input  logic                  pop_ready,
  output logic                  valid,
  output logic [DATA_WIDTH-1:0] data,
  output logic                  not_full
);
  logic [DATA_WIDTH-1:0] slot_q [AXIS_BUF_DEPTH];
  logic [DATA_WIDTH-1:0] slot_d [AXIS_BUF_DEPTH];
  axis_ptr_t head_q, head_d, tail_q, tail_d;
  axis_cnt_t cnt_q, cnt_d;
  logic      live_q;
  logic      pop;
  assign valid    = cnt_q != '0;
  assign data     = slot_q[head_q];
  // live_q keeps the producer side closed while in reset and until the first edge after it
  assign not_full = live_q && (cnt_q != axis_cnt_t'(AXIS_BUF_DEPTH));
  assign pop      = valid && pop_ready;
  always_comb begin
    slot_d = slot_q;
    if (push) slot_d[tail_q] = push_data;
    tail_d = tail_q + axis_ptr_t'(push);
    head_d = head_q + axis_ptr_t'(pop);
    cnt_d  = cnt_q + axis_cnt_t'(push) - axis_cnt_t'(pop);
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < AXIS_BUF_DEPTH; i++) slot_q[i] <= '0;
      head_q <= '0;
      tail_q <= '0;
      cnt_q  <= '0;
      live_q <= 1'b0;
    end else begin
      slot_q <= slot_d;
      head_q <= head_d;
      tail_q <= tail_d;
      cnt_q  <= cnt_d;
      live_q <= 1'b1;
    end
  end
endmodule

// File: rtl/axis_separator_2.sv
// axis_separator_2: splits each accepted beat into two independently drained output streams.
module axis_separator_2
  import axis_pkg::*;
#(
  parameter int DATA_WIDTH_0 = 16,
  parameter int DATA_WIDTH_1 = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    input_valid,
  input  logic [DATA_WIDTH_0-1:0] input_data_0,
  input  logic [DATA_WIDTH_1-1:0] input_data_1,
  output logic                    input_ready,
  output logic                    output_0_valid,
  output logic [DATA_WIDTH_0-1:0] output_0_data,
  input  logic                    output_0_ready,
  output logic                    output_1_valid,
  output logic [DATA_WIDTH_1-1:0] output_1_data,
  input  logic                    output_1_ready
);
  logic push, nf0, nf1;
  assign push        = input_valid && input_ready;
  assign input_ready = nf0 && nf1;
  axis_buffer_2 #(.DATA_WIDTH(DATA_WIDTH_0)) u_buf0 (
    .clk(clk), .rst(rst), .push(push), .push_data(input_data_0),
    .pop_ready(output_0_ready), .valid(output_0_valid), .data(output_0_data), .not_full(nf0)
  );
  axis_buffer_2 #(.DATA_WIDTH(DATA_WIDTH_1)) u_buf1 (
    .clk(clk), .rst(rst), .push(push), .push_data(input_data_1),
    .pop_ready(output_1_ready), .valid(output_1_valid), .data(output_1_data), .not_full(nf1)
  );
endmodule

// File: tb/tb_axis_separator_2.sv
// tb_axis_separator_2: directed and random checks against a queue-based model of the separator.
module tb_axis_separator_2;
  logic        clk = 0, rst = 0;
  logic        input_valid = 0, input_ready;
  logic [15:0] input_data_0 = 0, output_0_data;
  logic        input_data_1 = 0, output_1_data;
  logic        output_0_valid, output_0_ready = 0;
  logic        output_1_valid, output_1_ready = 0;
  int checks = 0, failures = 0;
  logic [15:0] q0 [$];
  logic        q1 [$];
  logic live = 0, last_push = 0;
  int pops0 = 0, pops1 = 0, accepted = 0;

  axis_separator_2 dut (
    .clk(clk), .rst(rst),
    .input_valid(input_valid), .input_data_0(input_data_0), .input_data_1(input_data_1),
    .input_ready(input_ready),
    .output_0_valid(output_0_valid), .output_0_data(output_0_data), .output_0_ready(output_0_ready),
    .output_1_valid(output_1_valid), .output_1_data(output_1_data), .output_1_ready(output_1_ready)
  );

  always #5 clk = ~clk;

  function automatic logic m_ready();
    return live && q0.size() < 2 && q1.size() < 2;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One cycle: compare outputs with the model, drive inputs, advance both across the edge.
  task automatic cycle(input logic iv, input logic [15:0] d0, input logic d1, input logic r0, input logic r1);
    logic p0, p1;
    chk("input_ready", input_ready, m_ready());
    chk("o0_valid", output_0_valid, q0.size() != 0);
    chk("o1_valid", output_1_valid, q1.size() != 0);
    if (q0.size() != 0) chk("o0_data", output_0_data, q0[0]);
    if (q1.size() != 0) chk("o1_data", output_1_data, q1[0]);
    input_valid = iv; input_data_0 = d0; input_data_1 = d1;
    output_0_ready = r0; output_1_ready = r1;
    #1;
    chk("ready_comb", input_ready, m_ready());
    last_push = iv && m_ready();
    p0 = q0.size() != 0 && r0;
    p1 = q1.size() != 0 && r1;
    @(posedge clk);
    if (p0) begin void'(q0.pop_front()); pops0++; end
    if (p1) begin void'(q1.pop_front()); pops1++; end
    if (last_push) begin q0.push_back(d0); q1.push_back(d1); accepted++; end
    live = rst;
    @(negedge clk);
  endtask

  initial begin
    int idx, n;
    #1;
    chk("rst_ready", input_ready, 0);
    chk("rst_v0", output_0_valid, 0);
    chk("rst_v1", output_1_valid, 0);
    chk("rst_d0", output_0_data, 0);
    chk("rst_d1", output_1_data, 0);
    @(negedge clk); @(negedge clk);
    rst = 1;
    cycle(0, 0, 0, 1, 1);
    chk("ready_after_rst", input_ready, 1);
    // 4 beats, consumers always ready
    for (int i = 1; i <= 4; i++) begin
      cycle(1, 16'(i), i[0], 1, 1);
      chk("stream_accept", last_push, 1);
    end
    for (int i = 0; i < 3; i++) cycle(0, 0, 0, 1, 1);
    chk("stream_pops0", pops0, 4);
    chk("stream_pops1", pops1, 4);
    // port 1 stalled, port 0 ready
    idx = 0;
    for (int c = 0; c < 6; c++) begin
      cycle(1, 16'h10 + 16'(idx), idx[0], 1, 0);
      if (last_push) idx++;
    end
    chk("p1stall_accepted", idx, 2);
    chk("p1stall_ready", input_ready, 0);
    n = 0;
    while ((idx < 4 || q0.size() != 0 || q1.size() != 0) && n < 30) begin
      cycle(idx < 4, 16'h10 + 16'(idx), idx[0], 1, 1);
      if (last_push) idx++;
      n++;
    end
    chk("p1stall_drained", n < 30, 1);
    // both stalled, 3 beats offered with held data
    idx = 0;
    for (int c = 0; c < 5; c++) begin
      cycle(1, 16'h20 + 16'(idx), idx[0], 0, 0);
      if (last_push) idx++;
    end
    chk("bothstall_accepted", idx, 2);
    chk("bothstall_ready", input_ready, 0);
    pops0 = 0; pops1 = 0; n = 0;
    while ((idx < 3 || q0.size() != 0 || q1.size() != 0) && n < 30) begin
      cycle(idx < 3, 16'h20 + 16'(idx), idx[0], 1, 1);
      if (last_push) idx++;
      n++;
    end
    chk("bothstall_pops0", pops0, 3);
    chk("bothstall_pops1", pops1, 3);
    // alternating consumer ready
    idx = 0; pops0 = 0; pops1 = 0; n = 0;
    while ((idx < 8 || q0.size() != 0 || q1.size() != 0) && n < 60) begin
      cycle(idx < 8, 16'h30 + 16'(idx), idx[0], n[0], !n[0]);
      if (last_push) idx++;
      n++;
    end
    chk("alt_pops0", pops0, 8);
    chk("alt_pops1", pops1, 8);
    // reset with two beats buffered per branch
    for (int i = 0; i < 3; i++) cycle(1, 16'h40 + 16'(i), 1'(i), 0, 0);
    chk("prerst_v0", output_0_valid, 1);
    rst = 0;
    #1;
    q0.delete(); q1.delete(); live = 0;
    chk("midrst_v0", output_0_valid, 0);
    chk("midrst_v1", output_1_valid, 0);
    chk("midrst_ready", input_ready, 0);
    chk("midrst_d0", output_0_data, 0);
    cycle(1, 16'h55, 1, 1, 1);
    rst = 1;
    cycle(0, 0, 0, 1, 1);
    chk("postrst_ready", input_ready, 1);
    chk("postrst_v0", output_0_valid, 0);
    chk("postrst_v1", output_1_valid, 0);
    // random traffic, 10k beats
    accepted = 0; pops0 = 0; pops1 = 0; n = 0;
    while (accepted < 10000 && n < 40000) begin
      cycle($urandom_range(0, 3) != 0, 16'($urandom), 1'($urandom),
            $urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0);
      if (pops0 - pops1 > 2 || pops1 - pops0 > 2) chk("skew", pops0 - pops1, 0);
      n++;
    end
    chk("random_budget", accepted >= 10000, 1);
    n = 0;
    while ((q0.size() != 0 || q1.size() != 0) && n < 10) begin
      cycle(0, 0, 0, 1, 1);
      n++;
    end
    chk("random_pops0", pops0, accepted);
    chk("random_pops1", pops1, accepted);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
